// File: rtl/seq_mult_ctrl.sv
// ----------------------------------------------------------------------------
// seq_mult_ctrl
//
// Purpose
//   Unsigned sequential multiplier. A single row of WIDTH bit-multiplier cells
//   (AND gate plus full-adder) is reused once per multiplier bit. Each RUN
//   cycle adds the shifted partial product (mcand & mplier[0]) << cnt into a
//   2*WIDTH-bit accumulator. Operands with a zero value skip RUN and finish
//   straight away with a zero product.
//
// Ports
//   clk_i      : sole clock, rising-edge
//   rst_ni     : asynchronous active-low reset
//   start_i    : request a multiply, sampled only while IDLE
//   abort_i    : synchronous cancel while RUN, wins over start_i in IDLE
//   a_i        : multiplicand (unsigned), sampled on the accepting edge
//   b_i        : multiplier (unsigned), sampled on the accepting edge
//   busy_o     : high whenever the state is not IDLE
//   done_o     : single-cycle pulse when product_o has just been updated
//   product_o  : last completed product, held until the next completion
// ----------------------------------------------------------------------------
module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [PW-1:0]    product_q;

  // --------------------------------------------------------------------------
  // Cell row: the WIDTH-bit accumulator window starting at bit cnt is added to
  // the partial product. The bits of acc_q at and above cnt+WIDTH are always
  // zero at this point (the running sum is below 2^(WIDTH+cnt)), so the row's
  // carry-out lands in a known-empty bit and no further carry chain is needed.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] row_win;
  logic [WIDTH-1:0] row_pp;
  logic [WIDTH-1:0] row_sum;
  logic [WIDTH:0]   row_c;

  assign row_win  = WIDTH'(acc_q >> cnt_q);
  assign row_c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign row_pp[i]    = mcand_q[i] & mplier_q[0];
    assign row_sum[i]   = row_win[i] ^ row_pp[i] ^ row_c[i];
    assign row_c[i + 1] = (row_win[i] & row_pp[i]) |
                          (row_win[i] & row_c[i])  |
                          (row_pp[i]  & row_c[i]);
  end

  // Recombine: keep the already-final low bits below cnt, replace the window
  // (plus its carry bit) with the row result.
  logic [PW-1:0] low_mask;
  logic [PW-1:0] row_ext;
  logic [PW-1:0] acc_d;

  assign low_mask = ~({PW{1'b1}} << cnt_q);
  assign row_ext  = {{(PW - WIDTH - 1){1'b0}}, row_c[WIDTH], row_sum};
  assign acc_d    = (acc_q & low_mask) | (row_ext << cnt_q);

  logic zero_op;
  assign zero_op = (a_i == '0) || (b_i == '0);

  // --------------------------------------------------------------------------
  // Control FSM with registered datapath and outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort has priority: a simultaneous start is dropped.
          if (start_i && !abort_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            if (zero_op) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              product_q <= '0;
            end else begin
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          if (abort_i) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
          end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              product_q <= acc_d;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 a  input  WIDTH  multiplicand, unsigned.
REQ-007 b  input  WIDTH  multiplier, unsigned.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking a valid product.
REQ-010 product  output  2*WIDTH  last completed result, unsigned.

Function
REQ-011 The block SHALL instantiate one row of WIDTH bit-multiplier cells (AND plus sum/carry) and reuse it once per multiplier bit; no full array.
REQ-012 States SHALL be IDLE, RUN and DONE, with a 2-bit encoding.
REQ-013 IDLE with start=1 SHALL capture a into mcand_r, b into mplier_r, clear acc_r (2*WIDTH bits) and clear bit counter cnt.
- Next state is RUN if both operands are non-zero.
- Next state is DONE if either operand is zero (zero shortcut).
REQ-014 Each RUN cycle SHALL set acc_r to acc_r + (mplier_r[0] ? mcand_r << cnt : 0), computed through the cell row.
- Shift mplier_r right by 1.
- Increment cnt.
- Arithmetic is exact and modulo 2^(2*WIDTH); overflow is impossible by construction.
REQ-015 RUN SHALL last exactly WIDTH cycles; on the cycle with cnt = WIDTH-1, next state is DONE.
REQ-016 On entry to DONE, product SHALL load acc_r, or 0 on the zero shortcut; done=1 for that single cycle; next state is IDLE.
REQ-017 Latency from the start-sampling edge to done high SHALL be WIDTH+1 cycles for non-zero operands and 1 cycle on the zero shortcut.
REQ-018 product SHALL hold its value from DONE until the next DONE, and is unaffected by a and b in between.
REQ-019 start in RUN or DONE SHALL be ignored, with no queuing; the earliest new acceptance is the IDLE cycle after DONE.
REQ-020 abort=1 in RUN SHALL return the block to IDLE on the next edge.
- No done pulse.
- product is unchanged.
- acc_r, mplier_r and cnt are cleared.
REQ-021 abort=1 in IDLE or DONE SHALL have no effect; when abort and start are both high in IDLE, abort has priority and the start is dropped.
REQ-022 a and b SHALL be don't-care outside the start-sampling cycle.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE, and is purely a decode of state.

Reset
REQ-024 rst_n=0 SHALL immediately force the following, independent of clk:
- state = IDLE;
- busy = 0, done = 0, product = 0;
- acc_r, mcand_r, mplier_r and cnt = 0.
REQ-025 Reset asserted mid-RUN SHALL discard the operation; no done pulse follows release.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification (WIDTH=8)
REQ-027 start, a=255, b=255 -> done 9 cycles later, product=65025, busy high for 9 cycles.
REQ-028 start, a=0, b=77 -> done on the next cycle, product=0; likewise for a=77, b=0.
REQ-029 start, a=13, b=11; start pulsed again with a=2, b=2 at cycle 4 -> one done, product=143; the second request is lost.
REQ-030 start, a=200, b=3; abort at cycle 5 -> busy low at cycle 6, no done, product keeps its previous value.
REQ-031 start, a=100, b=100; rst_n pulsed low at cycle 3 -> outputs 0 immediately, no later done; a subsequent start with a=6, b=7 -> product=42 after 9 cycles.
REQ-032 Back-to-back: start held high continuously with a=1, b=128 -> done every 10 cycles, product=128 each time.
